// File: rtl/encrypt_channel_arbiter.sv
// encrypt_channel_arbiter
// Shares one byte-wide encrypt/decrypt unit between NUM_REQ requesters.
// A round-robin arbiter issues at most one byte per cycle to the unit. Each
// issued byte's requester id goes into an in-flight tag FIFO. Each unit
// result is popped against that FIFO and returned with its id. Issue is
// credit-limited so that the tag FIFO can never overflow.
// Optional build macro: ARB_GRANT_COUNT_EN adds per-requester 16-bit grant
// counters on output grant_cnt.
module encrypt_channel_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [8*NUM_REQ-1:0]           req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           unit_en,
  output logic [7:0]                     unit_din,
  input  logic                           unit_v,
  input  logic [7:0]                     unit_dout,
  output logic                           rsp_valid,
  output logic [7:0]                     rsp_data,
  output logic [ID_W-1:0]                rsp_id,
  output logic [$clog2(MAX_INFLIGHT):0]  inflight,
  output logic                           err_orphan
`ifdef ARB_GRANT_COUNT_EN
  ,
  output logic [16*NUM_REQ-1:0]          grant_cnt
`endif
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  // Arbitration and issue state
  logic [ID_W-1:0]  r_ptr;
  logic             r_unit_en;
  logic [7:0]       r_unit_din;

  // Result path state
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_err_orphan;

  // Tag FIFO. Its occupancy is, by definition, the outstanding byte count.
  logic [ID_W-1:0]  r_tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_inflight;

  logic             w_found;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_credit;
  logic             w_hs;
  logic             w_empty;
  logic             w_pop;
  logic             w_orphan;
  logic [7:0]       w_gnt_byte;
  logic [ID_W-1:0]  w_head_tag;
  logic [ID_W-1:0]  w_ptr_next;

  // Round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and synthesis cannot infer a latch.
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // A full FIFO may still accept a push when a result frees a slot this cycle.
  // At full occupancy the FIFO is non-empty, so that result is never an orphan.
  assign w_credit   = (r_inflight < CNT_W'(MAX_INFLIGHT)) ||
                      ((r_inflight == CNT_W'(MAX_INFLIGHT)) && unit_v);
  assign w_hs       = !rst && w_found && w_credit;
  assign req_ready  = w_hs ? (NUM_REQ'(1) << w_gnt_id) : '0;
  assign w_gnt_byte = req_data[8*int'(w_gnt_id) +: 8];
  assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  // Emptiness is judged before this cycle's push, so a push and a result in
  // the same cycle on an empty FIFO do not bypass: the result is an orphan.
  assign w_empty    = (r_inflight == '0);
  assign w_pop      = unit_v && !w_empty;
  assign w_orphan   = unit_v && w_empty;
  assign w_head_tag = r_tag_mem[r_rd_ptr];

  // Pointer, unit drive, response register, FIFO pointers/count, orphan flag
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every right-hand
    // side reads the value from before this edge, whatever the statement order.
    if (rst) begin
      r_ptr        <= '0;
      r_unit_en    <= 1'b0;
      r_unit_din   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_err_orphan <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_inflight   <= '0;
    end else begin
      r_unit_en   <= w_hs;
      r_rsp_valid <= w_pop;
      if (w_hs) begin
        r_ptr      <= w_ptr_next;
        r_unit_din <= w_gnt_byte;
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rsp_data <= unit_dout;
        r_rsp_id   <= w_head_tag;
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_hs, w_pop})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  // Tag storage write port
  always_ff @(posedge clk) begin
    // NOTE: the tag storage has no reset. Clearing the pointers and the count
    // already makes every entry unreachable, so stale contents are harmless.
    if (w_hs) begin
      r_tag_mem[r_wr_ptr] <= w_gnt_id;
    end
  end

  assign unit_en    = r_unit_en;
  assign unit_din   = r_unit_din;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign inflight   = r_inflight;
  assign err_orphan = r_err_orphan;

`ifdef ARB_GRANT_COUNT_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  // Per-requester handshake counters; wrap naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= '0;
      end
    end else if (w_hs) begin
      r_grant_cnt[w_gnt_id] <= r_grant_cnt[w_gnt_id] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign grant_cnt[16*gi +: 16] = r_grant_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_encrypt_channel_arbiter.sv
// tb_encrypt_channel_arbiter
// Directed bench for encrypt_channel_arbiter. A behavioural fixed-latency unit
// (result = din ^ 8'hA5) sits on the unit interface. Handshakes and responses
// are logged on the falling edge. The expected values are hand-computed
// constants.
module tb_encrypt_channel_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int MAX_INFLIGHT = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 unit_en;
  logic [7:0]           unit_din;
  logic                 unit_v = 1'b0;
  logic [7:0]           unit_dout = 8'h00;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [$clog2(MAX_INFLIGHT):0] inflight;
  logic                 err_orphan;
`ifdef ARB_GRANT_COUNT_EN
  logic [16*NUM_REQ-1:0] grant_cnt;
`endif

  encrypt_channel_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .unit_en(unit_en), .unit_din(unit_din),
    .unit_v(unit_v), .unit_dout(unit_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .inflight(inflight), .err_orphan(err_orphan)
`ifdef ARB_GRANT_COUNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
  } pipe_t;

  pipe_t      pipe_q[$];
  int         grant_q[$];
  int         rid_q[$];
  logic [7:0] rdat_q[$];
  int         cyc      = 0;
  int         lat      = 3;
  logic       force_v  = 1'b0;
  int         n_grants = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  // Fixed-latency unit model: in order, no stall, reset together with the DUT
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      pipe_q.delete();
      unit_v = 1'b0;
    end else begin
      if (unit_en) pipe_q.push_back('{due: cyc + lat, data: unit_din ^ 8'hA5});
      if (force_v) begin
        unit_v    = 1'b1;
        unit_dout = 8'h5A;
      end else if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
        unit_v    = 1'b1;
        unit_dout = pipe_q[0].data;
        void'(pipe_q.pop_front());
      end else begin
        unit_v = 1'b0;
      end
    end
  end

  // Handshake and response logger, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_q.push_back(i);
          n_grants++;
        end
      end
      if (rsp_valid) begin
        rid_q.push_back(int'(rsp_id));
        rdat_q.push_back(rsp_data);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    grant_q.delete();
    rid_q.delete();
    rdat_q.delete();
  endtask

  task automatic run_until_grants(input int n, input int budget);
    int k = 0;
    while (grant_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("grant_budget", 32'(grant_q.size() >= n), 32'd1);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int         rr_id  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [7:0] rr_dat [8] = '{8'hB5, 8'h84, 8'h97, 8'hE6, 8'hB5, 8'h84, 8'h97, 8'hE6};
  int         cr_id  [5] = '{0, 1, 2, 3, 0};
  int         sp_id  [4] = '{1, 3, 1, 3};
  logic [7:0] sp_dat [4] = '{8'h84, 8'hE6, 8'h84, 8'hE6};

  initial begin
    int k;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    repeat (3) tick();

    // Reset state, with every requester asking
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_unit_en", 32'(unit_en), 32'h0);
    check("rst_unit_din", 32'(unit_din), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_inflight", 32'(inflight), 32'h0);
    check("rst_err_orphan", 32'(err_orphan), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Round robin at latency 3: 8 grants 0,1,2,3,0,1,2,3
    lat = 3;
    clear_logs();
    req_valid = '1;
    run_until_grants(8, 40);
    req_valid = '0;
    repeat (12) tick();
    check("rr_n_grants", 32'(grant_q.size()), 32'd8);
    check("rr_n_rsp", 32'(rid_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_grant%0d", i), 32'(q_at(grant_q, i)), 32'(rr_id[i]));
      check($sformatf("rr_rsp_id%0d", i), 32'(q_at(rid_q, i)), 32'(rr_id[i]));
      check($sformatf("rr_rsp_data%0d", i),
            (i < rdat_q.size()) ? 32'(rdat_q[i]) : 32'hFFFF_FFFF, 32'(rr_dat[i]));
    end
    check("rr_inflight_drained", 32'(inflight), 32'h0);

    // Credit limit at latency 10: 4 issues, stall, then a grant in the unit_v cycle
    lat = 10;
    clear_logs();
    req_valid = '1;
    repeat (8) tick();
    check("cr_n_grants_stalled", 32'(grant_q.size()), 32'd4);
    check("cr_ready_stalled", 32'(req_ready), 32'h0);
    check("cr_inflight_full", 32'(inflight), 32'd4);
    k = 0;
    while (!unit_v && k < 20) begin
      tick();
      k++;
    end
    check("cr_unit_v_seen", 32'(unit_v), 32'd1);
    #1;
    check("cr_ready_on_free", 32'(req_ready), 32'b0001);
    tick();
    check("cr_inflight_after_swap", 32'(inflight), 32'd4);
    check("cr_n_grants_after_swap", 32'(grant_q.size()), 32'd5);
    req_valid = '0;
    repeat (15) tick();
    check("cr_inflight_drained", 32'(inflight), 32'h0);
    check("cr_n_rsp", 32'(rid_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("cr_rsp_id%0d", i), 32'(q_at(rid_q, i)), 32'(cr_id[i]));
    end

    // Sparse fairness: only 1 and 3 valid, pointer currently 1
    lat = 2;
    clear_logs();
    req_valid = 4'b1010;
    run_until_grants(4, 20);
    req_valid = '0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sp_grant%0d", i), 32'(q_at(grant_q, i)), 32'(sp_id[i]));
      check($sformatf("sp_rsp_id%0d", i), 32'(q_at(rid_q, i)), 32'(sp_id[i]));
      check($sformatf("sp_rsp_data%0d", i),
            (i < rdat_q.size()) ? 32'(rdat_q[i]) : 32'hFFFF_FFFF, 32'(sp_dat[i]));
    end

    // Reset mid-stream: 3 bytes outstanding (grants 0,1,2 leave pointer at 3)
    lat = 10;
    clear_logs();
    req_valid = '1;
    run_until_grants(3, 20);
    req_valid = '0;
    check("rm_inflight_before", 32'(inflight), 32'd3);
    rst = 1'b1;
    req_valid = '1;
    #1;
    check("rm_ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    check("rm_inflight", 32'(inflight), 32'h0);
    check("rm_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rm_err_orphan", 32'(err_orphan), 32'h0);
    rst = 1'b0;
    #1;
    check("rm_next_grant_req0", 32'(req_ready), 32'b0001);
    req_valid = '0;
    clear_logs();
    repeat (15) tick();
    check("rm_no_stale_rsp", 32'(rid_q.size()), 32'd0);
    check("rm_inflight_idle", 32'(inflight), 32'h0);

    // Orphan result: unit_v with the FIFO empty
    clear_logs();
    force_v = 1'b1;
    tick();
    force_v = 1'b0;
    tick();
    check("or_err_set", 32'(err_orphan), 32'd1);
    check("or_inflight", 32'(inflight), 32'h0);
    repeat (4) tick();
    check("or_err_sticky", 32'(err_orphan), 32'd1);
    check("or_no_rsp", 32'(rid_q.size()), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("or_err_cleared", 32'(err_orphan), 32'h0);

`ifdef ARB_GRANT_COUNT_EN
    // Grant counter wrap: 70000 grants to requester 2
    lat = 1;
    clear_logs();
    n_grants = 0;
    req_valid = 4'b0100;
    k = 0;
    while (n_grants < 70000 && k < 75000) begin
      tick();
      k++;
    end
    req_valid = '0;
    check("gc_budget", 32'(n_grants), 32'd70000);
    repeat (4) tick();
    check("gc_req2", 32'(grant_cnt[47:32]), 32'd4464);
    check("gc_req0", 32'(grant_cnt[15:0]), 32'd0);
    check("gc_req1", 32'(grant_cnt[31:16]), 32'd0);
    check("gc_req3", 32'(grant_cnt[63:48]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encrypt_channel_arbiter.md
Name: encrypt_channel_arbiter

Overview:
- Shares one byte-wide encrypt (or decrypt) unit between NUM_REQ independent requesters.
- Unit interface: en/din strobe in; v/dout strobe out, in order, no stall.
- Block arbitrates round-robin, drives the unit, and tags each issued byte with its requester id in an in-flight tag FIFO.
- Routes each unit result back out with that id; caps outstanding bytes so the tag FIFO cannot overflow.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= NUM_REQ.
- MAX_INFLIGHT, 4, maximum bytes issued to the unit and not yet returned; also the tag FIFO depth (power of 2, 2..16).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant (or zero); handshake completes when req_valid[i] & req_ready[i].
- unit_en  out  1  issue strobe to the shared unit (drives its en).
- unit_din  out  8  byte to the unit (drives its din).
- unit_v  in  1  unit result valid (from its v).
- unit_dout  in  8  unit result byte (from its dout).
- rsp_valid  out  1  result byte valid, one-cycle pulse.
- rsp_data  out  8  result byte.
- rsp_id  out  ID_W  requester that issued this byte.
- inflight  out  clog2(MAX_INFLIGHT)+1  current outstanding count.
- err_orphan  out  1  sticky; unit_v seen with tag FIFO empty.

Behaviour:
- Reset (synchronous, sampled on clk rising edge while rst=1):
  - All outputs 0; req_ready=0.
  - Round-robin pointer = 0; tag FIFO emptied; inflight=0; err_orphan cleared.
  - The shared unit is reset by the same rst, so results in flight are discarded. There is no drain.
- Arbitration (combinational on current-cycle inputs):
  - Search requesters starting at pointer, wrapping modulo NUM_REQ.
  - First i with req_valid[i]=1 gets req_ready[i]=1, provided credit is available.
  - Credit available when inflight < MAX_INFLIGHT, or inflight == MAX_INFLIGHT and unit_v=1 this cycle (same-cycle free allowed).
  - No credit, or no valid requester: req_ready=0.
  - At most one handshake per cycle.
- On handshake with requester g:
  - Next cycle: unit_en=1 and unit_din = byte g; otherwise unit_en=0 and unit_din holds its last value.
  - Tag g pushed to the tag FIFO in the handshake cycle.
  - Pointer <= (g+1) mod NUM_REQ. The pointer is unchanged when there is no handshake.
- Result path:
  - On unit_v=1 with FIFO non-empty: pop head tag.
  - Next cycle: rsp_valid=1, rsp_data=unit_dout, rsp_id=popped tag.
  - Results are returned in issue order.
- Orphan result: unit_v=1 with FIFO empty and no push this cycle sets err_orphan=1 and produces no rsp_valid.
  - Push and pop in the same cycle on an empty FIFO is not bypassed, so this case is also orphan.
  - By construction this cannot occur, because the unit latency is at least 1 cycle after unit_en.
- inflight:
  - +1 on handshake, −1 on non-orphan unit_v, net 0 when both occur in the same cycle.
  - Never exceeds MAX_INFLIGHT and never goes below 0.
- Requester rules:
  - A requester must hold req_valid and req_data stable until its handshake.
  - Dropping req_valid before the handshake is allowed; that byte is simply not taken.
- Latency: handshake at cycle T gives unit_en at T+1. Result at unit_v cycle U gives rsp_valid at U+1.
- Throughput: 1 byte per cycle while credit is available.
- Starvation-free: a continuously valid requester is granted within NUM_REQ handshakes.

Optional Feature:
- ARB_GRANT_COUNT_EN.
- Defined:
  - Adds output grant_cnt, width 16*NUM_REQ, one 16-bit counter per requester.
  - Counter i increments on each handshake with requester i, wraps 0xFFFF→0x0000, and resets to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: 3 bytes in flight, assert rst for 1 cycle -> inflight=0, rsp_valid=0, req_ready=0, err_orphan=0. The next grant goes to requester 0 if valid.
- Round robin: all 4 req_valid=1 continuously, pointer=0 -> grants 0,1,2,3,0,… Each rsp_id matches the issue order. rsp_data equals the unit transform of 0x10,0x21,0x32,0x43 when driven with those bytes.
- Credit limit: unit latency held at 10 cycles, all requesters valid -> exactly 4 handshakes, then req_ready=0 until the first unit_v. A grant occurs in that same unit_v cycle and inflight stays 4.
- Sparse fairness: only requesters 1 and 3 valid -> grants alternate 1,3,1,3. Pointer skips 0 and 2.
- Orphan: force unit_v=1 with the FIFO empty -> err_orphan=1 next cycle and stays set. No rsp_valid is produced. Cleared only by rst.
- ARB_GRANT_COUNT_EN: 70000 grants to requester 2 -> grant_cnt[47:32] = 70000 mod 65536 = 4464. Other counters are 0.
